// File: rtl/branch_comp_seq.sv
`default_nettype none
// ============================================================================
// Module   : branch_comp_seq
// Purpose  : Multi-cycle RV32I/RV64I branch comparator, CWIDTH bits per cycle,
//            MSB chunk first, early exit on the first unequal chunk.
// Revision : 1.0 - initial release
// ============================================================================
module branch_comp_seq #(
   parameter int DWIDTH = 64,
   parameter int CWIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] DataA,
   input  logic [DWIDTH-1:0] DataB,
   input  logic [2:0]        funct3,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              BrEq,
   output logic              BrLt,
   output logic              Taken,
   output logic              Illegal
);

   localparam int NCH  = DWIDTH / CWIDTH;
   localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IDXW-1:0] c_IDX_TOP = IDXW'(NCH - 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_CMP  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   logic [1:0]        r_state;
   logic [1:0]        w_nextState;
   logic [DWIDTH-1:0] r_a;
   logic [DWIDTH-1:0] r_b;
   logic [2:0]        r_funct3;
   logic [IDXW-1:0]   r_idx;
   logic              r_brEq;
   logic              r_brLt;

   logic              w_accept;
   logic              w_signedMode;
   logic [CWIDTH-1:0] w_chunkA [NCH];
   logic [CWIDTH-1:0] w_chunkB [NCH];
   logic [CWIDTH-1:0] w_cmpA;
   logic [CWIDTH-1:0] w_cmpB;
   logic              w_chunkEq;
   logic              w_chunkLt;
   logic              w_lastChunk;
   logic              w_taken;

   for (genvar i = 0; i < NCH; i++) begin : g_chunk
      assign w_chunkA[i] = r_a[i*CWIDTH +: CWIDTH];
      assign w_chunkB[i] = r_b[i*CWIDTH +: CWIDTH];
   end

   // Only BLTU/BGEU compare unsigned; illegal encodings fall back to signed.
   assign w_signedMode = !(r_funct3[2] && r_funct3[1]);

   // Flipping the sign bit of the top chunk turns a signed compare into an unsigned one.
   always_comb begin
      w_cmpA = w_chunkA[r_idx];
      w_cmpB = w_chunkB[r_idx];
      if (w_signedMode && (r_idx == c_IDX_TOP)) begin
         w_cmpA[CWIDTH-1] = ~w_chunkA[r_idx][CWIDTH-1];
         w_cmpB[CWIDTH-1] = ~w_chunkB[r_idx][CWIDTH-1];
      end
   end

   assign w_chunkEq   = (w_cmpA == w_cmpB);
   assign w_chunkLt   = (w_cmpA < w_cmpB);
   assign w_lastChunk = (r_idx == '0);
   assign w_accept    = in_valid && in_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         c_IDLE: if (w_accept) w_nextState = c_CMP;
         c_CMP:  if (!w_chunkEq || w_lastChunk) w_nextState = c_DONE;
         c_DONE: if (out_ready) w_nextState = w_accept ? c_CMP : c_IDLE;
         default: w_nextState = c_IDLE;
      endcase
      if (flush) begin
         w_nextState = c_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_funct3 <= '0;
         r_idx    <= '0;
         r_brEq   <= 1'b0;
         r_brLt   <= 1'b0;
      end else if (w_accept) begin
         r_a      <= DataA;
         r_b      <= DataB;
         r_funct3 <= funct3;
         r_idx    <= c_IDX_TOP;
      end else if ((r_state == c_CMP) && !flush) begin
         if (!w_chunkEq) begin
            r_brEq <= 1'b0;
            r_brLt <= w_chunkLt;
         end else if (w_lastChunk) begin
            r_brEq <= 1'b1;
            r_brLt <= 1'b0;
         end else begin
            r_idx <= r_idx - 1'b1;
         end
      end
   end

   always_comb begin
      w_taken = 1'b0;
      case (r_funct3)
         3'b000:          w_taken = r_brEq;
         3'b001:          w_taken = !r_brEq;
         3'b100, 3'b110:  w_taken = r_brLt;
         3'b101, 3'b111:  w_taken = !r_brLt;
         default:         w_taken = 1'b0;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == c_IDLE) || ((r_state == c_DONE) && out_ready);
      out_valid = (r_state == c_DONE);
      BrEq      = out_valid && r_brEq;
      BrLt      = out_valid && r_brLt;
      Taken     = out_valid && w_taken;
      Illegal   = out_valid && (r_funct3[2:1] == 2'b01);
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_comp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_comp_seq
// Purpose  : Scoreboard bench for branch_comp_seq (DWIDTH=64, CWIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_comp_seq;

   localparam int DW  = 64;
   localparam int CW  = 16;
   localparam int NCH = DW / CW;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] DataA;
   logic [DW-1:0] DataB;
   logic [2:0]    funct3;
   logic          out_valid;
   logic          out_ready;
   logic          BrEq;
   logic          BrLt;
   logic          Taken;
   logic          Illegal;

   branch_comp_seq #(.DWIDTH(DW), .CWIDTH(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .DataA(DataA), .DataB(DataB), .funct3(funct3), .out_valid(out_valid),
      .out_ready(out_ready), .BrEq(BrEq), .BrLt(BrLt), .Taken(Taken), .Illegal(Illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] res;   // {BrEq, BrLt, Taken, Illegal}
      int         acc;
      int         k;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   orMode   = 1;   // 0 random, 1 always ready, 2 never ready
   logic headSeen = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: whole-operand arithmetic, chunk count from highest differing bit.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f);
      exp_t e;
      logic eq, lt, tk, il;
      logic [63:0] d;
      eq = (a == b);
      if (f == 3'b110 || f == 3'b111) lt = (a < b);
      else                            lt = ($signed(a) < $signed(b));
      il = (f == 3'b010 || f == 3'b011);
      case (f)
         3'b000: tk = eq;
         3'b001: tk = !eq;
         3'b100, 3'b110: tk = lt;
         3'b101, 3'b111: tk = !lt;
         default: tk = 1'b0;
      endcase
      d   = a ^ b;
      e.k = NCH;
      for (int p = 0; p < 64; p++) if (d[p]) e.k = NCH - (p / CW);
      e.res = {eq, lt, tk, il};
      e.acc = 0;
      return e;
   endfunction

   always @(posedge clk) begin
      #1;
      case (orMode)
         0:       out_ready = 1'($urandom_range(0, 1));
         1:       out_ready = 1'b1;
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
         q.delete();
         headSeen = 1'b0;
      end else begin
         if (q.size() == 0) begin
            chk("idle_in_ready", 64'(in_ready), 64'd1);
            chk("idle_out_valid", 64'(out_valid), 64'd0);
            chk("idle_outputs", 64'({BrEq, BrLt, Taken, Illegal}), 64'd0);
         end else if (!out_valid) begin
            chk("busy_in_ready", 64'(in_ready), 64'd0);
            chk("busy_outputs", 64'({BrEq, BrLt, Taken, Illegal}), 64'd0);
            if (cyc - q[0].acc > NCH + 20) begin
               chk("result_timeout", 64'(cyc - q[0].acc), 64'(1 + q[0].k));
               void'(q.pop_front());
               headSeen = 1'b0;
            end
         end else begin
            if (!headSeen) chk("latency", 64'(cyc - q[0].acc), 64'(1 + q[0].k));
            headSeen = 1'b1;
            chk("result", 64'({BrEq, BrLt, Taken, Illegal}), 64'(q[0].res));
            chk("done_in_ready", 64'(in_ready), 64'(out_ready));
            if (out_ready && !flush) begin
               void'(q.pop_front());
               headSeen = 1'b0;
            end
         end
         if (flush) begin
            q.delete();
            headSeen = 1'b0;
         end else if (in_valid && in_ready) begin
            e     = model(DataA, DataB, funct3);
            e.acc = cyc;
            q.push_back(e);
         end
      end
   end

   // Caller is at posedge+1; returns at posedge+1 after the accept edge.
   task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f);
      int n;
      DataA = a; DataB = b; funct3 = f; in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready && !flush) break;
         n++;
         if (n > 200) begin
            chk("accept_timeout", 64'(n), 64'd0);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a, b;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
      DataA = '0; DataB = '0; funct3 = '0;
      #1;
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_outputs", 64'({out_valid, BrEq, BrLt, Taken, Illegal}), 64'd0);
      ticks(3);
      rst = 1'b0;
      ticks(1);

      // Directed cases, always-ready consumer: back-to-back issue
      orMode = 1;
      issue(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 3'b000);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b100);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b110);
      issue(64'd5, 64'd5, 3'b101);
      issue(64'd7, 64'd9, 3'b010);
      issue(64'd9, 64'd7, 3'b011);
      ticks(8);

      // Consumer stalls for several cycles in DONE
      orMode = 2;
      issue(64'h8000_0000_0000_0000, 64'd3, 3'b111);
      ticks(8);
      orMode = 1;
      ticks(3);

      // Flush mid-compare, then a fresh op
      issue(64'hAAAA, 64'hAAAA, 3'b000);
      ticks(1);
      flush = 1'b1;
      ticks(1);
      flush = 1'b0;
      ticks(6);
      issue(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0001, 3'b110);
      ticks(8);

      // Async reset during compare
      issue(64'h55, 64'h55, 3'b001);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      ticks(2);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         orMode = (n % 50 < 25) ? 0 : 1;
         a = {$urandom, $urandom};
         b = a;
         for (int c = 0; c < NCH; c++)
            if ($urandom_range(0, 3) == 0) b[c*CW +: CW] = 16'($urandom);
         if ($urandom_range(0, 7) == 0) b[63] = ~b[63];
         issue(a, b, 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 9) == 0) ticks($urandom_range(1, 6));
      end

      orMode = 1;
      for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
      #1;
      chk("drain_queue", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
